// File: rtl/boid_frame_writer.sv
// Frame-synchronous boid rasteriser: swaps display buffers on frame_end, clears the
// new back buffer and emits one registered write per sprite pixel of every active boid.
module boid_frame_writer #(
    parameter int MAX_BOIDS  = 16,
    parameter int BOID_BITS  = $clog2(MAX_BOIDS),
    parameter int SCREEN_W   = 640,
    parameter int SCREEN_H   = 480,
    parameter int ADDR_WIDTH = 19,
    parameter int SPRITE     = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  frame_end,
    input  logic [BOID_BITS:0]    boid_count,
    output logic [BOID_BITS-1:0]  boid_sel,
    input  logic [9:0]            boid_x,
    input  logic [8:0]            boid_y,
    output logic                  disp_buf,
    output logic                  clear_req,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic                  busy,
    output logic                  overrun
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StClear = 2'd1;
    localparam logic [1:0] StWrite = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    localparam logic [1:0]            SprLast  = 2'(SPRITE - 1);
    localparam logic [BOID_BITS:0]    MaxCount = (BOID_BITS + 1)'(MAX_BOIDS);
    localparam logic [10:0]           ScreenWX = 11'(SCREEN_W);
    localparam logic [9:0]            ScreenHY = 10'(SCREEN_H);
    localparam logic [ADDR_WIDTH-1:0] ScreenWA = ADDR_WIDTH'(SCREEN_W);

    logic [1:0]            state_q, state_d;
    logic [BOID_BITS-1:0]  b_q, b_d;
    logic [1:0]            dx_q, dx_d;
    logic [1:0]            dy_q, dy_d;
    logic [BOID_BITS:0]    count_q, count_d;
    logic                  disp_q, disp_d;
    logic                  overrun_q, overrun_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;

    logic [BOID_BITS:0]    count_clamped;
    logic [10:0]           px;
    logic [9:0]            py;
    logic                  on_screen;
    logic                  last_boid;
    logic [ADDR_WIDTH-1:0] pix_addr;

    assign count_clamped = (boid_count > MaxCount) ? MaxCount : boid_count;
    assign px            = {1'b0, boid_x} + 11'(dx_q);
    assign py            = {1'b0, boid_y} + 10'(dy_q);
    assign on_screen     = (px < ScreenWX) && (py < ScreenHY);
    assign last_boid     = ({1'b0, b_q} == count_q - 1'b1);
    // Only meaningful when on_screen; off-screen addresses are never strobed.
    assign pix_addr      = ADDR_WIDTH'(py) * ScreenWA + ADDR_WIDTH'(px);

    always_comb begin
        state_d   = state_q;
        b_d       = b_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        count_d   = count_q;
        disp_d    = disp_q;
        overrun_d = overrun_q | (frame_end && (state_q != StIdle));
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;

        unique case (state_q)
            StIdle: begin
                if (frame_end) begin
                    state_d = StClear;
                    disp_d  = ~disp_q;
                end
            end
            StClear: begin
                count_d = count_clamped;
                b_d     = '0;
                dx_d    = '0;
                dy_d    = '0;
                state_d = (count_clamped == '0) ? StDone : StWrite;
            end
            StWrite: begin
                wr_en_d   = on_screen;
                wr_addr_d = pix_addr;
                if (dx_q != SprLast) begin
                    dx_d = dx_q + 2'd1;
                end else begin
                    dx_d = '0;
                    if (dy_q != SprLast) begin
                        dy_d = dy_q + 2'd1;
                    end else begin
                        dy_d = '0;
                        if (last_boid) state_d = StDone;
                        else           b_d     = b_q + 1'b1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StIdle;
            b_q       <= '0;
            dx_q      <= '0;
            dy_q      <= '0;
            count_q   <= '0;
            disp_q    <= 1'b0;
            overrun_q <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            b_q       <= b_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            count_q   <= count_d;
            disp_q    <= disp_d;
            overrun_q <= overrun_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
        end
    end

    assign boid_sel  = b_q;
    assign disp_buf  = disp_q;
    assign clear_req = (state_q == StClear);
    assign busy      = (state_q != StIdle);
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_boid_frame_writer.sv
// Directed bench for boid_frame_writer: a SPRITE=1 instance and a SPRITE=2 instance,
// each with its own boid position table.
module tb_boid_frame_writer;

    logic        clock = 1'b0;
    logic        reset;
    logic        fe1, fe2;
    logic [4:0]  cnt1, cnt2;
    logic [3:0]  sel1, sel2;
    logic [9:0]  x1, x2;
    logic [8:0]  y1, y2;
    logic        disp1, clr1, we1, busy1, ovr1;
    logic        disp2, clr2, we2, busy2, ovr2;
    logic [18:0] wa1, wa2;

    logic [9:0]  tx1 [16];
    logic [8:0]  ty1 [16];
    logic [9:0]  tx2 [16];
    logic [8:0]  ty2 [16];

    int   vecs = 0;
    int   errs = 0;
    logic exp_disp2 = 1'b0;

    assign x1 = tx1[sel1];
    assign y1 = ty1[sel1];
    assign x2 = tx2[sel2];
    assign y2 = ty2[sel2];

    always #10 clock = ~clock;

    boid_frame_writer #(.SPRITE(1)) dut1 (
        .clock(clock), .reset(reset), .frame_end(fe1), .boid_count(cnt1),
        .boid_sel(sel1), .boid_x(x1), .boid_y(y1), .disp_buf(disp1),
        .clear_req(clr1), .wr_en(we1), .wr_addr(wa1), .busy(busy1), .overrun(ovr1)
    );

    boid_frame_writer #(.SPRITE(2)) dut2 (
        .clock(clock), .reset(reset), .frame_end(fe2), .boid_count(cnt2),
        .boid_sel(sel2), .boid_x(x2), .boid_y(y2), .disp_buf(disp2),
        .clear_req(clr2), .wr_en(we2), .wr_addr(wa2), .busy(busy2), .overrun(ovr2)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; fe1 = 1'b0; fe2 = 1'b0; cnt1 = '0; cnt2 = '0;
        for (int i = 0; i < 16; i++) begin
            tx1[i] = '0; ty1[i] = '0; tx2[i] = '0; ty2[i] = '0;
        end
        tick();
        tick();
        vecs++;
        if ({disp1, clr1, we1, busy1, ovr1, sel1, wa1} !== 28'd0) begin
            errs++;
            $display("FAIL reset_dut1: got %h, expected 0", {disp1, clr1, we1, busy1, ovr1, sel1, wa1});
        end
        vecs++;
        if ({disp2, clr2, we2, busy2, ovr2, sel2, wa2} !== 28'd0) begin
            errs++;
            $display("FAIL reset_dut2: got %h, expected 0", {disp2, clr2, we2, busy2, ovr2, sel2, wa2});
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_sprite1_frame();
        logic [18:0] exp_a [3];
        exp_a[0] = 19'd12810; exp_a[1] = 19'd0; exp_a[2] = 19'd307199;
        tx1[0] = 10'd10;  ty1[0] = 9'd20;
        tx1[1] = 10'd0;   ty1[1] = 9'd0;
        tx1[2] = 10'd639; ty1[2] = 9'd479;
        cnt1 = 5'd3;
        fe1 = 1'b1;
        tick();
        fe1 = 1'b0;
        vecs++;
        if ({disp1, clr1, busy1, we1} !== 4'b1110) begin
            errs++;
            $display("FAIL s1_clear {disp,clr,busy,we}: got %b, expected 1110", {disp1, clr1, busy1, we1});
        end
        tick();
        vecs++;
        if ({clr1, we1, sel1} !== 6'd0) begin
            errs++;
            $display("FAIL s1_first_write {clr,we,sel}: got %b, expected 0", {clr1, we1, sel1});
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            vecs++;
            if (we1 !== 1'b1 || wa1 !== exp_a[i]) begin
                errs++;
                $display("FAIL s1_write%0d: got en=%b addr=%0d, expected en=1 addr=%0d",
                         i, we1, wa1, exp_a[i]);
            end
        end
        vecs++;
        if (busy1 !== 1'b1) begin
            errs++;
            $display("FAIL s1_done_busy: got %b, expected 1", busy1);
        end
        tick();
        vecs++;
        if ({busy1, we1, disp1} !== 3'b001) begin
            errs++;
            $display("FAIL s1_idle {busy,we,disp}: got %b, expected 001", {busy1, we1, disp1});
        end
    endtask

    task automatic test_sprite2_edge();
        logic        exp_en [4];
        logic [18:0] exp_a  [4];
        int          pulses = 0;
        exp_en[0] = 1'b1; exp_a[0] = 19'd3839;
        exp_en[1] = 1'b0; exp_a[1] = 19'd0;
        exp_en[2] = 1'b1; exp_a[2] = 19'd4479;
        exp_en[3] = 1'b0; exp_a[3] = 19'd0;
        tx2[0] = 10'd639; ty2[0] = 9'd5;
        cnt2 = 5'd1;
        fe2 = 1'b1;
        tick();
        fe2 = 1'b0;
        exp_disp2 = ~exp_disp2;
        vecs++;
        if (disp2 !== exp_disp2 || clr2 !== 1'b1) begin
            errs++;
            $display("FAIL s2_clear: got disp=%b clr=%b, expected disp=%b clr=1", disp2, clr2, exp_disp2);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            pulses += int'(we2);
            vecs++;
            if (we2 !== exp_en[i]) begin
                errs++;
                $display("FAIL s2_slot%0d_en: got %b, expected %b", i, we2, exp_en[i]);
            end
            if (exp_en[i]) begin
                vecs++;
                if (wa2 !== exp_a[i]) begin
                    errs++;
                    $display("FAIL s2_slot%0d_addr: got %0d, expected %0d", i, wa2, exp_a[i]);
                end
            end
        end
        tick();
        vecs++;
        if (pulses !== 2 || busy2 !== 1'b0) begin
            errs++;
            $display("FAIL s2_pulses: got pulses=%0d busy=%b, expected pulses=2 busy=0", pulses, busy2);
        end
    endtask

    task automatic test_zero_count();
        int nb, nc, nw;
        cnt2 = 5'd0;
        fe2 = 1'b1;
        tick();
        fe2 = 1'b0;
        exp_disp2 = ~exp_disp2;
        nb = int'(busy2); nc = int'(clr2); nw = int'(we2);
        vecs++;
        if (disp2 !== exp_disp2) begin
            errs++;
            $display("FAIL zero_disp: got %b, expected %b", disp2, exp_disp2);
        end
        repeat (6) begin
            tick();
            nb += int'(busy2); nc += int'(clr2); nw += int'(we2);
        end
        vecs++;
        if (nb !== 2 || nc !== 1 || nw !== 0) begin
            errs++;
            $display("FAIL zero_counts: got busy=%0d clr=%0d wr=%0d, expected busy=2 clr=1 wr=0",
                     nb, nc, nw);
        end
    endtask

    task automatic test_overrun();
        int nw = 0, nc = 0, sum = 0, exp_sum = 0;
        logic done = 1'b0;
        for (int b = 0; b < 16; b++) begin
            tx2[b] = 10'(b * 8);
            ty2[b] = 9'(b * 4);
            for (int dy = 0; dy < 2; dy++)
                for (int dx = 0; dx < 2; dx++)
                    exp_sum += (b * 4 + dy) * 640 + b * 8 + dx;
        end
        cnt2 = 5'd16;
        fe2 = 1'b1;
        tick();
        fe2 = 1'b0;
        exp_disp2 = ~exp_disp2;
        for (int k = 0; k < 200 && !done; k++) begin
            fe2 = (k == 9);
            tick();
            nw += int'(we2);
            nc += int'(clr2);
            if (we2) sum += int'(wa2);
            if (!busy2) done = 1'b1;
        end
        fe2 = 1'b0;
        vecs++;
        if (!done) begin
            errs++;
            $display("FAIL ovr_timeout: got busy=%b after 200 cycles, expected 0", busy2);
        end
        vecs++;
        if (ovr2 !== 1'b1 || disp2 !== exp_disp2 || nc !== 0) begin
            errs++;
            $display("FAIL ovr_flags: got ovr=%b disp=%b clr=%0d, expected ovr=1 disp=%b clr=0",
                     ovr2, disp2, nc, exp_disp2);
        end
        vecs++;
        if (nw !== 64 || sum !== exp_sum) begin
            errs++;
            $display("FAIL ovr_writes: got n=%0d sum=%0d, expected n=64 sum=%0d", nw, sum, exp_sum);
        end
    endtask

    task automatic test_clamp();
        int nw = 0, nb, sum = 0, maxsel = 0;
        logic done = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tx1[i] = 10'(i);
            ty1[i] = 9'(i);
        end
        cnt1 = 5'd20;
        fe1 = 1'b1;
        tick();
        fe1 = 1'b0;
        nb = int'(busy1);
        for (int k = 0; k < 100 && !done; k++) begin
            tick();
            nb += int'(busy1);
            nw += int'(we1);
            if (we1) sum += int'(wa1);
            if (busy1 && int'(sel1) > maxsel) maxsel = int'(sel1);
            if (!busy1) done = 1'b1;
        end
        vecs++;
        if (!done || nb !== 18) begin
            errs++;
            $display("FAIL clamp_cycles: got busy=%0d done=%b, expected busy=18 done=1", nb, done);
        end
        vecs++;
        if (nw !== 16 || sum !== 76920 || maxsel !== 15) begin
            errs++;
            $display("FAIL clamp_writes: got n=%0d sum=%0d maxsel=%0d, expected n=16 sum=76920 maxsel=15",
                     nw, sum, maxsel);
        end
    endtask

    task automatic test_reset_mid_write();
        int   nw = 0;
        logic hit = 1'b0;
        cnt1 = 5'd16;
        fe1 = 1'b1;
        tick();
        fe1 = 1'b0;
        for (int k = 0; k < 50 && !hit; k++) begin
            tick();
            if (busy1 && !clr1 && sel1 == 4'd5) hit = 1'b1;
        end
        vecs++;
        if (!hit) begin
            errs++;
            $display("FAIL mid_reach_boid5: got sel=%0d, expected 5", sel1);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vecs++;
        if ({disp1, clr1, we1, busy1, ovr1, sel1, wa1} !== 28'd0) begin
            errs++;
            $display("FAIL mid_reset_outputs: got %h, expected 0", {disp1, clr1, we1, busy1, ovr1, sel1, wa1});
        end
        repeat (20) begin
            tick();
            nw += int'(we1);
        end
        vecs++;
        if (nw !== 0 || busy1 !== 1'b0) begin
            errs++;
            $display("FAIL mid_no_writes: got writes=%0d busy=%b, expected writes=0 busy=0", nw, busy1);
        end
    endtask

    initial begin
        test_reset();
        test_sprite1_frame();
        test_sprite2_edge();
        test_zero_count();
        test_overrun();
        test_clamp();
        test_reset_mid_write();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
